// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared funct3 encodings and grant codes for mem_arbiter
package mem_arbiter_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DB   = 2'd1,
    GNT_IF   = 2'd2,
    GNT_DM   = 2'd3
  } gnt_e;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rtl/mem_arbiter_rr_arbiter2.sv - two-way round-robin arbiter, req[0]=IF, req[1]=DM
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // Favour the loser of the most recent grant; cycles with no grant keep the pointer.
  always_ff @(posedge clk) begin
    if (rst)         ptr <= 1'b0;
    else if (gnt[0]) ptr <= 1'b1;
    else if (gnt[1]) ptr <= 1'b0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between debug loader, instruction fetch and data port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDRW    = 12,
  parameter int DATAW    = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             db_req,
  input  logic             db_we,
  input  logic [2:0]       db_funct3,
  input  logic [ADDRW-1:0] db_addr,
  input  logic [DATAW-1:0] db_wdata,
  output logic             db_gnt,
  output logic             db_rvalid,
  output logic [DATAW-1:0] db_rdata,
  input  logic             if_req,
  input  logic [ADDRW-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [DATAW-1:0] if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [2:0]       dm_funct3,
  input  logic [ADDRW-1:0] dm_addr,
  input  logic [DATAW-1:0] dm_wdata,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [DATAW-1:0] dm_rdata,
  output logic             mem_we,
  output logic [2:0]       mem_funct3,
  output logic [ADDRW-1:0] mem_addr,
  output logic [DATAW-1:0] mem_wdata,
  input  logic [DATAW-1:0] mem_rdata
);

  localparam logic [3:0] WAIT_SAT = 4'(MAX_WAIT);

  logic [3:0] wait_if, wait_dm;
  logic       starve_if, starve_dm, starve_any;
  logic [1:0] rr_req, rr_gnt;
  logic       rr_en;
  gnt_e       gnt_sel;
  logic       db_rvalid_q, if_rvalid_q, dm_rvalid_q;

  assign starve_if  = if_req && (wait_if == WAIT_SAT);
  assign starve_dm  = dm_req && (wait_dm == WAIT_SAT);
  assign starve_any = starve_if || starve_dm;
  assign rr_en      = !rst;

  // A saturated waiter outranks DB; otherwise DB masks IF/DM out of the round-robin.
  assign rr_req = starve_any ? {starve_dm, starve_if} :
                  (db_req ? 2'b00 : {dm_req, if_req});

  rr_arbiter2 u_rr (
    .clk (clk),
    .rst (rst),
    .en  (rr_en),
    .req (rr_req),
    .gnt (rr_gnt)
  );

  always_comb begin
    gnt_sel = GNT_NONE;
    if (!rst) begin
      if (rr_gnt[0])      gnt_sel = GNT_IF;
      else if (rr_gnt[1]) gnt_sel = GNT_DM;
      else if (db_req)    gnt_sel = GNT_DB;
    end
  end

  assign db_gnt = (gnt_sel == GNT_DB);
  assign if_gnt = (gnt_sel == GNT_IF);
  assign dm_gnt = (gnt_sel == GNT_DM);

  always_comb begin
    mem_we     = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (gnt_sel)
      GNT_DB: begin
        mem_we     = db_we;
        mem_funct3 = db_funct3;
        mem_addr   = db_addr;
        mem_wdata  = db_wdata;
      end
      GNT_IF: begin
        mem_funct3 = F3_LW;
        mem_addr   = if_addr;
      end
      GNT_DM: begin
        mem_we     = dm_we;
        mem_funct3 = dm_funct3;
        mem_addr   = dm_addr;
        mem_wdata  = dm_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_if <= 4'd0;
      wait_dm <= 4'd0;
    end else begin
      if (!if_req || if_gnt)       wait_if <= 4'd0;
      else if (wait_if != WAIT_SAT) wait_if <= wait_if + 4'd1;
      if (!dm_req || dm_gnt)       wait_dm <= 4'd0;
      else if (wait_dm != WAIT_SAT) wait_dm <= wait_dm + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_rvalid_q <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      db_rdata    <= '0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
    end else begin
      db_rvalid_q <= db_gnt && !db_we;
      if_rvalid_q <= if_gnt;
      dm_rvalid_q <= dm_gnt && !dm_we;
      if (db_gnt && !db_we) db_rdata <= mem_rdata;
      if (if_gnt)           if_rdata <= mem_rdata;
      if (dm_gnt && !dm_we) dm_rdata <= mem_rdata;
    end
  end

  // Gating with rst drops a response that was still in flight when reset arrived.
  assign db_rvalid = db_rvalid_q && !rst;
  assign if_rvalid = if_rvalid_q && !rst;
  assign dm_rvalid = dm_rvalid_q && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a byte-addressed memory model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDRW = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             db_req, db_we, db_gnt, db_rvalid;
  logic [2:0]       db_funct3;
  logic [ADDRW-1:0] db_addr;
  logic [31:0]      db_wdata, db_rdata;
  logic             if_req, if_gnt, if_rvalid;
  logic [ADDRW-1:0] if_addr;
  logic [31:0]      if_rdata;
  logic             dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [2:0]       dm_funct3;
  logic [ADDRW-1:0] dm_addr;
  logic [31:0]      dm_wdata, dm_rdata;
  logic             mem_we;
  logic [2:0]       mem_funct3;
  logic [ADDRW-1:0] mem_addr;
  logic [31:0]      mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:(1<<ADDRW)-1];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDRW(ADDRW), .DATAW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .db_req(db_req), .db_we(db_we), .db_funct3(db_funct3), .db_addr(db_addr),
    .db_wdata(db_wdata), .db_gnt(db_gnt), .db_rvalid(db_rvalid), .db_rdata(db_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_read(logic [ADDRW-1:0] a, logic [2:0] f3);
    logic [ADDRW-1:0] aw, a1;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    aw = {a[ADDRW-1:2], 2'b00};
    a1 = a + 1'b1;
    w  = {mem[aw + 3], mem[aw + 2], mem[aw + 1], mem[aw]};
    b  = mem[a];
    h  = {mem[a1], mem[a]};
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  assign mem_rdata = mem_read(mem_addr, mem_funct3);

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_funct3[1:0])
        2'b00: mem[mem_addr] <= mem_wdata[7:0];
        2'b01: begin
          mem[mem_addr]        <= mem_wdata[7:0];
          mem[mem_addr + 1'b1] <= mem_wdata[15:8];
        end
        default: begin
          mem[{mem_addr[ADDRW-1:2], 2'b00}] <= mem_wdata[7:0];
          mem[{mem_addr[ADDRW-1:2], 2'b01}] <= mem_wdata[15:8];
          mem[{mem_addr[ADDRW-1:2], 2'b10}] <= mem_wdata[23:16];
          mem[{mem_addr[ADDRW-1:2], 2'b11}] <= mem_wdata[31:24];
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    db_req = 1'b0; if_req = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDRW); i++) mem[i] = 8'h00;
    rst = 1'b1;
    db_req = 1'b1; db_we = 1'b0; db_funct3 = F3_LW; db_addr = '0; db_wdata = '0;
    if_req = 1'b1; if_addr = '0;
    dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = F3_LW; dm_addr = '0; dm_wdata = '0;

    // 1: reset with every requester active
    for (int c = 0; c < 3; c++) begin
      tick(); #2;
      chk("rst_gnts", {db_gnt, if_gnt, dm_gnt}, 32'd0);
      chk("rst_rvalid", {db_rvalid, if_rvalid, dm_rvalid}, 32'd0);
      chk("rst_db_rdata", db_rdata, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      chk("rst_mem_we", mem_we, 32'd0);
    end
    rst = 1'b0; idle();
    tick();

    // 2: DB write then DM word read
    db_req = 1'b1; db_we = 1'b1; db_funct3 = F3_SW; db_addr = 12'h100; db_wdata = 32'hDEADBEEF;
    #2;
    chk("t2_db_gnt", db_gnt, 32'd1);
    chk("t2_mem_we", mem_we, 32'd1);
    chk("t2_mem_addr", mem_addr, 32'h100);
    tick();
    db_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = F3_LW; dm_addr = 12'h100;
    #2;
    chk("t2_dm_gnt", dm_gnt, 32'd1);
    chk("t2_db_rvalid_wr", db_rvalid, 32'd0);
    tick();
    dm_req = 1'b0;
    #2;
    chk("t2_dm_rvalid", dm_rvalid, 32'd1);
    chk("t2_dm_rdata", dm_rdata, 32'hDEADBEEF);
    chk("t2_db_rvalid", db_rvalid, 32'd0);
    tick();
    chk("t2_dm_rvalid_drop", dm_rvalid, 32'd0);

    // 3: IF/DM alternation right after reset
    rst = 1'b1; tick(); rst = 1'b0;
    if_req = 1'b1; if_addr = 12'h000;
    dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = F3_LW; dm_addr = 12'h100;
    for (int c = 0; c < 6; c++) begin
      #2;
      chk("t3_if_gnt", if_gnt, (c % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_dm_gnt", dm_gnt, (c % 2 == 1) ? 32'd1 : 32'd0);
      if (c > 0) begin
        chk("t3_if_rvalid", if_rvalid, (c % 2 == 1) ? 32'd1 : 32'd0);
        chk("t3_dm_rvalid", dm_rvalid, (c % 2 == 0) ? 32'd1 : 32'd0);
      end
      tick();
    end
    idle(); tick();

    // 4: continuous DB starves IF until the wait counter saturates at 4
    db_req = 1'b1; db_we = 1'b0; db_funct3 = F3_LW; db_addr = 12'h100;
    if_req = 1'b1; if_addr = 12'h004;
    for (int c = 0; c < 10; c++) begin
      #2;
      chk("t4_db_gnt", db_gnt, (c % 5 == 4) ? 32'd0 : 32'd1);
      chk("t4_if_gnt", if_gnt, (c % 5 == 4) ? 32'd1 : 32'd0);
      tick();
    end
    idle(); tick();

    // 5: byte store into a word, then word and signed byte reads
    db_req = 1'b1; db_we = 1'b1; db_funct3 = F3_SW; db_addr = 12'h004; db_wdata = 32'h11223344;
    #2; chk("t5_db_gnt", db_gnt, 32'd1);
    tick(); db_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_funct3 = F3_SB; dm_addr = 12'h007; dm_wdata = 32'h000000AB;
    #2;
    chk("t5_sb_gnt", dm_gnt, 32'd1);
    chk("t5_sb_funct3", mem_funct3, 32'(F3_SB));
    tick();
    dm_we = 1'b0; dm_funct3 = F3_LW; dm_addr = 12'h004;
    #2;
    chk("t5_sb_no_rvalid", dm_rvalid, 32'd0);
    tick();
    dm_funct3 = F3_LB; dm_addr = 12'h007;
    #2;
    chk("t5_lw_rvalid", dm_rvalid, 32'd1);
    chk("t5_lw_rdata", dm_rdata, 32'hAB223344);
    tick();
    dm_req = 1'b0;
    #2;
    chk("t5_lb_rvalid", dm_rvalid, 32'd1);
    chk("t5_lb_rdata", dm_rdata, 32'hFFFFFFAB);
    tick();
    chk("t5_rvalid_drop", dm_rvalid, 32'd0);
    chk("t5_rdata_hold", dm_rdata, 32'hFFFFFFAB);

    // 6: reset right after an IF grant drops the response and re-favours IF
    if_req = 1'b1; if_addr = 12'h004;
    #2; chk("t6_if_gnt", if_gnt, 32'd1);
    tick();
    rst = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = F3_LW; dm_addr = 12'h100;
    #2;
    chk("t6_if_rvalid_rst", if_rvalid, 32'd0);
    chk("t6_gnt_rst", {db_gnt, if_gnt, dm_gnt}, 32'd0);
    tick();
    rst = 1'b0;
    #2;
    chk("t6_if_rvalid_post", if_rvalid, 32'd0);
    chk("t6_if_rdata_post", if_rdata, 32'd0);
    chk("t6_if_favoured", if_gnt, 32'd1);
    chk("t6_dm_waits", dm_gnt, 32'd0);
    tick();
    idle();
    #2;
    chk("t6_if_rvalid", if_rvalid, 32'd1);
    chk("t6_if_rdata", if_rdata, 32'hAB223344);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
